fifo_test_sequencer: RTL and testbench

Sequences one loopback test run over the master FIFO datapath. On start it pushes WORDS_PER_RUN pattern words into the TX FIFO, then drains the same number of words from the RX FIFO and compares each against the expected pattern. It reports busy/done/pass status, an error count and a timeout flag, and drives the two EVM LEDs. It replaces free-running receive checking with a restartable, bounded test run.

---
 rtl/fifo_test_sequencer_if.sv | 35 +++
 rtl/fifo_test_sequencer.sv | 176 +++++++++++++++++
 tb/tb_fifo_test_sequencer.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_test_sequencer_if.sv
// fifo_test_sequencer_if: handshake bundle between the test sequencer and the
// master FIFO datapath.
//   tx_ready  TX FIFO can accept a word this cycle
//   tx_write  TX write strobe (word transfers on an edge with tx_write=1)
//   tx_data   TX pattern word
//   rx_valid  RX FIFO presents a valid word
//   rx_read   RX read strobe (word transfers on an edge with rx_valid & rx_read)
//   rx_data   RX word
// master: sequencer side. slave: FIFO side.
interface fifo_test_sequencer_if;
  logic        tx_ready;
  logic        tx_write;
  logic [31:0] tx_data;
  logic        rx_valid;
  logic        rx_read;
  logic [31:0] rx_data;

  modport master (
    input  tx_ready,
    output tx_write,
    output tx_data,
    input  rx_valid,
    output rx_read,
    input  rx_data
  );

  modport slave (
    output tx_ready,
    input  tx_write,
    input  tx_data,
    output rx_valid,
    input  rx_read,
    output rx_data
  );
endinterface

// File: rtl/fifo_test_sequencer.sv
// fifo_test_sequencer: runs one bounded loopback test over the master FIFO
// datapath. On start it pushes WORDS_PER_RUN pattern words into the TX FIFO,
// then drains the same number of words from the RX FIFO, comparing each
// against the expected pattern. A run aborts if no transfer happens for
// TIMEOUT_CYCLES cycles.
//
// Ports:
//   clk_in        system clock
//   rst           synchronous, active-high reset
//   start         run request, sampled only in IDLE or DONE
//   fifo          TX/RX handshake bundle (master modport)
//   busy          run in progress (TX or RX)
//   done          run finished
//   pass          done with no mismatches and no timeout
//   timeout_flag  last run aborted on timeout
//   err_count     mismatching words, saturating at 16'hFFFF
//   evm_led       [0]=done, [1]=pass
//
// Build option: define FIFO_TEST_SEQ_LFSR_EN to use a 32-bit Galois LFSR
// pattern (x^32+x^22+x^2+x+1, seed PATTERN_SEED, 0 forced to 1) instead of
// the incrementing pattern PATTERN_SEED + index.
module fifo_test_sequencer #(
  parameter int unsigned WORDS_PER_RUN  = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter logic [31:0] PATTERN_SEED   = 32'h0000_0000
) (
  input  logic                         clk_in,
  input  logic                         rst,
  input  logic                         start,
  fifo_test_sequencer_if.master        fifo,
  output logic                         busy,
  output logic                         done,
  output logic                         pass,
  output logic                         timeout_flag,
  output logic [15:0]                  err_count,
  output logic [1:0]                   evm_led
);

  localparam logic [15:0] LastWord  = 16'(WORDS_PER_RUN - 1);
  localparam logic [31:0] TimerLast = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StTx, StRx, StDone} state_e;

  state_e      state_q, state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [15:0] err_q, err_d;
  logic [31:0] timer_q, timer_d;
  logic        to_q, to_d;
  logic [31:0] tx_pat, rx_pat;

`ifdef FIFO_TEST_SEQ_LFSR_EN
  localparam logic [31:0] LfsrSeed = (PATTERN_SEED == 32'h0) ? 32'h1 : PATTERN_SEED;
  // Right-shifting Galois form: taps at x^32, x^22, x^2, x^1.
  localparam logic [31:0] LfsrMask = 32'h8020_0003;

  function automatic logic [31:0] lfsr_step(logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LfsrMask) : (s >> 1);
  endfunction

  logic [31:0] tx_lfsr_q, tx_lfsr_d;
  logic [31:0] rx_lfsr_q, rx_lfsr_d;

  assign tx_pat = tx_lfsr_q;
  assign rx_pat = rx_lfsr_q;
`else
  assign tx_pat = PATTERN_SEED + {16'h0, tx_cnt_q};
  assign rx_pat = PATTERN_SEED + {16'h0, rx_cnt_q};
`endif

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q   <= StIdle;
      tx_cnt_q  <= '0;
      rx_cnt_q  <= '0;
      err_q     <= '0;
      timer_q   <= '0;
      to_q      <= 1'b0;
`ifdef FIFO_TEST_SEQ_LFSR_EN
      tx_lfsr_q <= LfsrSeed;
      rx_lfsr_q <= LfsrSeed;
`endif
    end else begin
      state_q   <= state_d;
      tx_cnt_q  <= tx_cnt_d;
      rx_cnt_q  <= rx_cnt_d;
      err_q     <= err_d;
      timer_q   <= timer_d;
      to_q      <= to_d;
`ifdef FIFO_TEST_SEQ_LFSR_EN
      tx_lfsr_q <= tx_lfsr_d;
      rx_lfsr_q <= rx_lfsr_d;
`endif
    end
  end

  always_comb begin
    state_d       = state_q;
    tx_cnt_d      = tx_cnt_q;
    rx_cnt_d      = rx_cnt_q;
    err_d         = err_q;
    timer_d       = timer_q;
    to_d          = to_q;
    fifo.tx_write = 1'b0;
    fifo.tx_data  = 32'h0;
    fifo.rx_read  = 1'b0;
`ifdef FIFO_TEST_SEQ_LFSR_EN
    tx_lfsr_d     = tx_lfsr_q;
    rx_lfsr_d     = rx_lfsr_q;
`endif

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          tx_cnt_d  = '0;
          rx_cnt_d  = '0;
          err_d     = '0;
          timer_d   = '0;
          to_d      = 1'b0;
          state_d   = StTx;
`ifdef FIFO_TEST_SEQ_LFSR_EN
          tx_lfsr_d = LfsrSeed;
          rx_lfsr_d = LfsrSeed;
`endif
        end
      end

      StTx: begin
        fifo.tx_write = fifo.tx_ready;
        fifo.tx_data  = tx_pat;
        // A transfer wins over a timeout in the same cycle.
        if (fifo.tx_ready) begin
          tx_cnt_d  = tx_cnt_q + 16'd1;
          timer_d   = '0;
`ifdef FIFO_TEST_SEQ_LFSR_EN
          tx_lfsr_d = lfsr_step(tx_lfsr_q);
`endif
          if (tx_cnt_q == LastWord) state_d = StRx;
        end else if (timer_q == TimerLast) begin
          to_d    = 1'b1;
          state_d = StDone;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end

      StRx: begin
        fifo.rx_read = 1'b1;
        if (fifo.rx_valid) begin
          rx_cnt_d  = rx_cnt_q + 16'd1;
          timer_d   = '0;
          if ((fifo.rx_data != rx_pat) && (err_q != 16'hFFFF)) err_d = err_q + 16'd1;
`ifdef FIFO_TEST_SEQ_LFSR_EN
          rx_lfsr_d = lfsr_step(rx_lfsr_q);
`endif
          if (rx_cnt_q == LastWord) state_d = StDone;
        end else if (timer_q == TimerLast) begin
          to_d    = 1'b1;
          state_d = StDone;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  assign busy         = (state_q == StTx) || (state_q == StRx);
  assign done         = (state_q == StDone);
  assign pass         = done && (err_q == 16'h0) && !to_q;
  assign timeout_flag = to_q;
  assign err_count    = err_q;
  assign evm_led      = {pass, done};

endmodule

// File: tb/tb_fifo_test_sequencer.sv
// Bench for fifo_test_sequencer: a loopback FIFO model feeds TX words back to
// RX; a table of run scenarios is applied in a loop, plus hand sequences for
// reset state and reset in the middle of RX.
module tb_fifo_test_sequencer;

  localparam int unsigned Words   = 1024;
  localparam int unsigned Timeout = 16;
  localparam logic [31:0] Seed    = 32'h0000_0000;

  logic        clk_in = 1'b0;
  logic        rst;
  logic        start;
  logic        tx_ready;
  logic        rx_en;
  logic        busy, done, pass, timeout_flag;
  logic [15:0] err_count;
  logic [1:0]  evm_led;

  int errors = 0;
  int checks = 0;

  fifo_test_sequencer_if fifo_bus ();

  fifo_test_sequencer #(
    .WORDS_PER_RUN (Words),
    .TIMEOUT_CYCLES(Timeout),
    .PATTERN_SEED  (Seed)
  ) dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .start       (start),
    .fifo        (fifo_bus),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .timeout_flag(timeout_flag),
    .err_count   (err_count),
    .evm_led     (evm_led)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [31:0] first_pat();
`ifdef FIFO_TEST_SEQ_LFSR_EN
    return (Seed == 32'h0) ? 32'h1 : Seed;
`else
    return Seed;
`endif
  endfunction

  function automatic logic [31:0] next_pat(logic [31:0] x);
`ifdef FIFO_TEST_SEQ_LFSR_EN
    return x[0] ? ((x >> 1) ^ 32'h8020_0003) : (x >> 1);
`else
    return x + 32'd1;
`endif
  endfunction

  // Loopback FIFO model and monitors.
  logic [31:0] mem [Words];
  logic [15:0] wp, rp;
  logic [31:0] exp_tx;
  int          viol, tx_bad;
  int          cyc = 0;
  int          last_xfer = 0;
  logic        fifo_clr;
  int          cur_corrupt;

  assign fifo_bus.tx_ready = tx_ready;
  assign fifo_bus.rx_valid = rx_en && (rp < wp);
  assign fifo_bus.rx_data  = (int'(rp) == cur_corrupt) ? 32'hDEAD_BEEF : mem[rp[9:0]];

  always @(posedge clk_in) begin
    cyc <= cyc + 1;
    if (fifo_clr) begin
      wp     <= '0;
      rp     <= '0;
      viol   <= 0;
      tx_bad <= 0;
      exp_tx <= first_pat();
    end else begin
      if (fifo_bus.tx_write && !tx_ready) viol <= viol + 1;
      if (fifo_bus.tx_write) begin
        if (fifo_bus.tx_data != exp_tx) tx_bad <= tx_bad + 1;
        if (wp < 16'(Words)) mem[wp[9:0]] <= fifo_bus.tx_data;
        wp        <= wp + 16'd1;
        exp_tx    <= next_pat(exp_tx);
        last_xfer <= cyc;
      end
      if (fifo_bus.rx_read && fifo_bus.rx_valid) begin
        rp        <= rp + 16'd1;
        last_xfer <= cyc;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        tx_toggle;
    int          rx_gap;
    int          corrupt_idx;
    int          stall_after;
    int          restart_at;
    logic        chk_lat;
    logic [15:0] exp_reads;
    logic        exp_pass;
    logic [15:0] exp_err;
    logic        exp_to;
    logic [1:0]  exp_led;
  } scen_t;

  scen_t tbl [6];

  task automatic clear_model();
    @(posedge clk_in); #1;
    fifo_clr = 1'b1;
    @(posedge clk_in); #1;
    fifo_clr = 1'b0;
  endtask

  task automatic run_scenario(input int idx, input scen_t sc);
    int   start_edge, done_edge, gap_cnt;
    logic seen_done;
    cur_corrupt = sc.corrupt_idx;
    tx_ready    = 1'b1;
    rx_en       = 1'b1;
    clear_model();
    start = 1'b1;
    @(posedge clk_in); #1;
    start      = 1'b0;
    start_edge = cyc - 1;
    seen_done  = 1'b0;
    done_edge  = 0;
    gap_cnt    = 1;
    for (int c = 0; c < 20000 && !seen_done; c++) begin
      if (done) begin
        seen_done = 1'b1;
        done_edge = cyc - 1;
      end else begin
        @(posedge clk_in); #1;
        tx_ready = sc.tx_toggle ? ~tx_ready : 1'b1;
        if (sc.rx_gap == 0) begin
          rx_en = 1'b1;
        end else begin
          rx_en   = (gap_cnt == 0);
          gap_cnt = (gap_cnt == sc.rx_gap) ? 0 : gap_cnt + 1;
        end
        if (sc.stall_after >= 0 && int'(rp) >= sc.stall_after) rx_en = 1'b0;
        start = (c == sc.restart_at);
      end
    end
    start = 1'b0;
    check($sformatf("s%0d done", idx), {31'h0, seen_done}, 32'h1);
    check($sformatf("s%0d busy", idx), {31'h0, busy}, 32'h0);
    check($sformatf("s%0d pass", idx), {31'h0, pass}, {31'h0, sc.exp_pass});
    check($sformatf("s%0d err_count", idx), {16'h0, err_count}, {16'h0, sc.exp_err});
    check($sformatf("s%0d timeout_flag", idx), {31'h0, timeout_flag}, {31'h0, sc.exp_to});
    check($sformatf("s%0d evm_led", idx), {30'h0, evm_led}, {30'h0, sc.exp_led});
    check($sformatf("s%0d tx_words", idx), {16'h0, wp}, Words);
    check($sformatf("s%0d rx_words", idx), {16'h0, rp}, {16'h0, sc.exp_reads});
    check($sformatf("s%0d tx_order", idx), tx_bad, 0);
    check($sformatf("s%0d write_without_ready", idx), viol, 0);
    // Start edge to DONE entry: 2*Words edges, i.e. done in cycle 2*Words+1.
    if (sc.chk_lat) check($sformatf("s%0d latency", idx), done_edge - start_edge, 2 * Words);
    if (sc.stall_after >= 0)
      check($sformatf("s%0d timeout_gap", idx), done_edge - last_xfer, Timeout);
  endtask

  initial begin
    //            tog   gap cor  stall rst  lat  reads       pass  err    to    led
    tbl[0] = '{1'b0, 0, -1,   -1,  -1, 1'b1, 16'd1024, 1'b1, 16'd0, 1'b0, 2'b11};
    tbl[1] = '{1'b0, 0,  5,   -1,  -1, 1'b1, 16'd1024, 1'b0, 16'd1, 1'b0, 2'b01};
    tbl[2] = '{1'b1, 3, -1,   -1,  -1, 1'b0, 16'd1024, 1'b1, 16'd0, 1'b0, 2'b11};
    tbl[3] = '{1'b0, 0, -1,   10,  -1, 1'b0, 16'd10,   1'b0, 16'd0, 1'b1, 2'b01};
    tbl[4] = '{1'b0, 0, 1023, -1,  -1, 1'b1, 16'd1024, 1'b0, 16'd1, 1'b0, 2'b01};
    tbl[5] = '{1'b0, 0, -1,   -1, 100, 1'b1, 16'd1024, 1'b1, 16'd0, 1'b0, 2'b11};

    rst         = 1'b1;
    start       = 1'b0;
    tx_ready    = 1'b1;
    rx_en       = 1'b0;
    fifo_clr    = 1'b1;
    cur_corrupt = -1;
    repeat (3) @(posedge clk_in);
    #1;
    check("rst busy", {31'h0, busy}, 32'h0);
    check("rst done", {31'h0, done}, 32'h0);
    check("rst pass", {31'h0, pass}, 32'h0);
    check("rst timeout_flag", {31'h0, timeout_flag}, 32'h0);
    check("rst err_count", {16'h0, err_count}, 32'h0);
    check("rst evm_led", {30'h0, evm_led}, 32'h0);
    check("rst tx_write", {31'h0, fifo_bus.tx_write}, 32'h0);
    check("rst rx_read", {31'h0, fifo_bus.rx_read}, 32'h0);
    check("rst tx_data", fifo_bus.tx_data, 32'h0);
    rst      = 1'b0;
    fifo_clr = 1'b0;

    for (int i = 0; i < 6; i++) run_scenario(i, tbl[i]);

    // Reset in the middle of RX after a corrupted word has been counted.
    cur_corrupt = 5;
    tx_ready    = 1'b1;
    rx_en       = 1'b1;
    clear_model();
    start = 1'b1;
    @(posedge clk_in); #1;
    start = 1'b0;
    for (int c = 0; c < 5000 && rp < 16'd100; c++) begin
      @(posedge clk_in); #1;
    end
    check("midrx reached", {16'h0, rp}, 32'd100);
    check("midrx err_before", {16'h0, err_count}, 32'd1);
    rst = 1'b1;
    @(posedge clk_in); #1;
    rst = 1'b0;
    check("midrx busy", {31'h0, busy}, 32'h0);
    check("midrx done", {31'h0, done}, 32'h0);
    check("midrx err_count", {16'h0, err_count}, 32'h0);
    check("midrx rx_read", {31'h0, fifo_bus.rx_read}, 32'h0);
    check("midrx tx_write", {31'h0, fifo_bus.tx_write}, 32'h0);
    run_scenario(6, tbl[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
